// File: rtl/branch_unit_pkg.sv
// rtl/branch_unit_pkg.sv - shared opcode patterns, condition codes, flag and phase indices
package branch_unit_pkg;

   // One-hot phase vector bit positions
   localparam int PHASE_W = 5;
   localparam int PH_F    = 0;
   localparam int PH_D    = 1;
   localparam int PH_X    = 2;
   localparam int PH_M    = 3;
   localparam int PH_W    = 4;

   // Flags register bit positions
   localparam int FLAGS_W = 4;
   localparam int F_S     = 3;
   localparam int F_Z     = 2;
   localparam int F_C     = 1;
   localparam int F_V     = 0;

   // Decode patterns over {op1, op2}; op2 is always a don't-care
   localparam logic [9:0] Z_JMP  = 10'b1100_0000_??;
   localparam logic [9:0] Z_JCC  = 10'b1100_0001_??;
   localparam logic [9:0] Z_CALL = 10'b1100_0010_??;
   localparam logic [9:0] Z_RET  = 10'b1100_0011_??;

   // Jcc condition codes (op3)
   localparam logic [2:0] CC_AL = 3'b000;
   localparam logic [2:0] CC_EQ = 3'b001;
   localparam logic [2:0] CC_NE = 3'b010;
   localparam logic [2:0] CC_CS = 3'b011;
   localparam logic [2:0] CC_CC = 3'b100;
   localparam logic [2:0] CC_LT = 3'b101;
   localparam logic [2:0] CC_GE = 3'b110;
   localparam logic [2:0] CC_LE = 3'b111;

   typedef enum logic [2:0] {
      BK_NONE = 3'd0,
      BK_JMP  = 3'd1,
      BK_JCC  = 3'd2,
      BK_CALL = 3'd3,
      BK_RET  = 3'd4
   } br_kind_t;

   // Classify an instruction from its opcode fields
   function automatic br_kind_t decode_kind(input logic [7:0] op1, input logic [1:0] op2);
      br_kind_t k;
      k = BK_NONE;
      casez ({op1, op2})
         Z_JMP:   k = BK_JMP;
         Z_JCC:   k = BK_JCC;
         Z_CALL:  k = BK_CALL;
         Z_RET:   k = BK_RET;
         default: k = BK_NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/branch_unit_ret_stack.sv
// rtl/branch_unit_ret_stack.sv - circular return-address LIFO that overwrites its oldest entry when full
module ret_stack #(
   parameter int PC_W     = 8,
   parameter int RS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] dout,
   output logic            empty
);

   localparam int PTR_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RS_DEPTH + 1);

   logic [PC_W-1:0]  r_mem [RS_DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] w_top;

   // r_ptr is the next write slot, so the top entry sits one below it
   assign w_top = r_ptr - PTR_W'(1);
   assign dout  = r_mem[w_top];
   assign empty = (r_count == '0);

   // Push wraps the pointer and overwrites the oldest slot; occupancy saturates at the depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_count <= '0;
         for (int i = 0; i < RS_DEPTH; i++) r_mem[i] <= '0;
      end else if (push) begin
         r_mem[r_ptr] <= din;
         r_ptr        <= r_ptr + PTR_W'(1);
         if (r_count != CNT_W'(RS_DEPTH)) r_count <= r_count + CNT_W'(1);
      end else if (pop && !empty) begin
         r_ptr   <= w_top;
         r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - phase-sequenced branch resolver: latch decision at decode, redirect PC at writeback
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int RS_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] phase,
   input  logic [7:0]         op1,
   input  logic [1:0]         op2,
   input  logic [2:0]         op3,
   input  logic [FLAGS_W-1:0] flags_in,
   input  logic [PC_W-1:0]    target,
   output logic [PC_W-1:0]    pc_out,
   output logic               taken,
   output logic               rs_err
);

   // Evaluate a Jcc condition code against the flags
   function automatic logic cond_eval(input logic [2:0] cc, input logic [FLAGS_W-1:0] fl);
      logic s, z, c, v, res;
      s   = fl[F_S];
      z   = fl[F_Z];
      c   = fl[F_C];
      v   = fl[F_V];
      res = 1'b0;
      case (cc)
         CC_AL:   res = 1'b1;
         CC_EQ:   res = z;
         CC_NE:   res = !z;
         CC_CS:   res = c;
         CC_CC:   res = !c;
         CC_LT:   res = s ^ v;
         CC_GE:   res = !(s ^ v);
         CC_LE:   res = z | (s ^ v);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   br_kind_t        r_kind;
   logic            r_dec;
   logic [PC_W-1:0] r_pc;
   logic            r_taken;
   logic            r_err;

   br_kind_t        w_kind;
   logic            w_dec;
   logic            w_one_hot;
   logic            w_d, w_w, w_f;
   logic            w_rs_empty;
   logic [PC_W-1:0] w_rs_dout;
   logic            w_ret_underflow;
   logic            w_redirect;
   logic            w_push, w_pop;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_dest;

   // Decode and condition evaluation for the instruction currently presented
   always_comb begin
      w_kind = decode_kind(op1, op2);
      w_dec  = 1'b0;
      case (w_kind)
         BK_JMP, BK_CALL, BK_RET: w_dec = 1'b1;
         BK_JCC:                  w_dec = cond_eval(op3, flags_in);
         default:                 w_dec = 1'b0;
      endcase
   end

   // Illegal (zero or multi-hot) phase vectors are ignored entirely
   assign w_one_hot = (phase != '0) && ((phase & (phase - PHASE_W'(1))) == '0);
   assign w_d       = w_one_hot && phase[PH_D];
   assign w_w       = w_one_hot && phase[PH_W];
   assign w_f       = w_one_hot && phase[PH_F];

   // A RET with nothing to pop degrades to fall-through and flags the underflow
   assign w_ret_underflow = r_dec && (r_kind == BK_RET) && w_rs_empty;
   assign w_redirect      = r_dec && !w_ret_underflow;
   assign w_push          = w_w && r_dec && (r_kind == BK_CALL);
   assign w_pop           = w_w && r_dec && (r_kind == BK_RET) && !w_rs_empty;
   assign w_pc_inc        = r_pc + PC_W'(1);
   assign w_dest          = (r_kind == BK_RET) ? w_rs_dout : target;

   // Latch at decode, apply and consume at writeback, clear taken at fetch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_kind  <= BK_NONE;
         r_dec   <= 1'b0;
         r_pc    <= '0;
         r_taken <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_d) begin
         r_kind <= w_kind;
         r_dec  <= w_dec;
      end else if (w_w) begin
         r_pc    <= w_redirect ? w_dest : w_pc_inc;
         r_taken <= w_redirect;
         if (w_ret_underflow) r_err <= 1'b1;
         r_kind  <= BK_NONE;
         r_dec   <= 1'b0;
      end else if (w_f) begin
         r_taken <= 1'b0;
      end
   end

   ret_stack #(
      .PC_W     (PC_W),
      .RS_DEPTH (RS_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst_n (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_pc_inc),
      .dout  (w_rs_dout),
      .empty (w_rs_empty)
   );

   assign pc_out = r_pc;
   assign taken  = r_taken;
   assign rs_err = r_err;

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - randomized self-checking bench for branch_unit against a queue-based model
module tb_branch_unit;

   logic       clk;
   logic       rst;
   logic [4:0] phase;
   logic [7:0] op1;
   logic [1:0] op2;
   logic [2:0] op3;
   logic [3:0] flags_in;
   logic [7:0] target;
   logic [7:0] pc_out;
   logic       taken;
   logic       rs_err;

   int n_cmp;
   int n_bad;

   int m_pc;
   bit m_taken;
   bit m_err;
   int m_stk[$];

   localparam logic [4:0] P_F = 5'b00001;
   localparam logic [4:0] P_D = 5'b00010;
   localparam logic [4:0] P_X = 5'b00100;
   localparam logic [4:0] P_M = 5'b01000;
   localparam logic [4:0] P_W = 5'b10000;

   branch_unit #(.PC_W(8), .RS_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .phase    (phase),
      .op1      (op1),
      .op2      (op2),
      .op3      (op3),
      .flags_in (flags_in),
      .target   (target),
      .pc_out   (pc_out),
      .taken    (taken),
      .rs_err   (rs_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pulse(input logic [4:0] ph);
      @(negedge clk);
      phase = ph;
      @(posedge clk);
      #1;
      phase = '0;
   endtask

   function automatic bit m_cond(input int cc, input logic [3:0] fl);
      bit s, z, c, v;
      s = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
      case (cc)
         0: return 1;
         1: return z;
         2: return !z;
         3: return c;
         4: return !c;
         5: return s != v;
         6: return s == v;
         default: return z || (s != v);
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 0; m_taken = 0; m_err = 0; m_stk.delete();
   endtask

   // Whole-instruction effect as seen after writeback, using the flags present at decode
   task automatic model_instr(input logic [7:0] o1, input logic [2:0] o3, input logic [3:0] fl, input logic [7:0] tgt);
      bit dec;
      dec = (o1 == 8'hC0) || (o1 == 8'hC2) || (o1 == 8'hC3) || (o1 == 8'hC1 && m_cond(int'(o3), fl));
      if (dec && o1 == 8'hC3 && m_stk.size() == 0) begin
         m_err = 1; dec = 0;
      end
      if (!dec) begin
         m_pc = (m_pc + 1) % 256; m_taken = 0;
      end else begin
         if (o1 == 8'hC2) begin
            m_stk.push_back((m_pc + 1) % 256);
            if (m_stk.size() > 4) void'(m_stk.pop_front());
         end
         if (o1 == 8'hC3) m_pc = m_stk.pop_back();
         else m_pc = int'(tgt);
         m_taken = 1;
      end
   endtask

   task automatic run_instr(input logic [7:0] o1, input logic [2:0] o3, input logic [3:0] fl_d,
                            input logic [3:0] fl_w, input logic [7:0] tgt);
      op1 = o1; op2 = 2'($urandom); op3 = o3; target = tgt; flags_in = fl_d;
      pulse(P_F);
      pulse(P_D);
      flags_in = fl_w;
      pulse(P_X);
      pulse(P_M);
      pulse(P_W);
      model_instr(o1, o3, fl_d, tgt);
   endtask

   task automatic test_reset();
      rst = 1'b0; phase = '0; op1 = '0; op2 = '0; op3 = '0; flags_in = '0; target = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (pc_out !== 8'h00) begin n_bad++; $display("FAIL reset_pc got %h want 00", pc_out); end
      n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken got %b want 0", taken); end
      n_cmp++; if (rs_err !== 1'b0) begin n_bad++; $display("FAIL reset_rs_err got %b want 0", rs_err); end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         run_instr(8'h12, 3'd0, 4'h0, 4'h0, 8'hAA);
         n_cmp++; if (pc_out !== 8'(i)) begin n_bad++; $display("FAIL seq_pc%0d got %h want %h", i, pc_out, 8'(i)); end
         n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL seq_taken%0d got %b want 0", i, taken); end
      end
   endtask

   task automatic test_jcc_flags_after_decode();
      run_instr(8'hC0, 3'd0, 4'h0, 4'h0, 8'h10);
      run_instr(8'hC1, 3'b001, 4'b0100, 4'b0000, 8'h40);
      n_cmp++; if (pc_out !== 8'h40) begin n_bad++; $display("FAIL jcc_eq_pc got %h want 40", pc_out); end
      n_cmp++; if (taken !== 1'b1) begin n_bad++; $display("FAIL jcc_eq_taken got %b want 1", taken); end
      run_instr(8'hC1, 3'b101, 4'b1001, 4'b1000, 8'h40);
      n_cmp++; if (pc_out !== 8'h41) begin n_bad++; $display("FAIL jcc_lt_pc got %h want 41", pc_out); end
      n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL jcc_lt_taken got %b want 0", taken); end
   endtask

   task automatic test_call_ret();
      logic [7:0] exp_ret [4];
      exp_ret[0] = 8'h06; exp_ret[1] = 8'h05; exp_ret[2] = 8'h04; exp_ret[3] = 8'h03;
      for (int i = 1; i <= 5; i++) begin
         run_instr(8'hC0, 3'd0, 4'h0, 4'h0, 8'(i));
         run_instr(8'hC2, 3'd0, 4'h0, 4'h0, 8'h80);
         n_cmp++; if (pc_out !== 8'h80) begin n_bad++; $display("FAIL call%0d_pc got %h want 80", i, pc_out); end
      end
      for (int i = 0; i < 4; i++) begin
         run_instr(8'hC3, 3'd0, 4'h0, 4'h0, 8'h77);
         n_cmp++; if (pc_out !== exp_ret[i]) begin n_bad++; $display("FAIL ret%0d_pc got %h want %h", i, pc_out, exp_ret[i]); end
         n_cmp++; if (taken !== 1'b1) begin n_bad++; $display("FAIL ret%0d_taken got %b want 1", i, taken); end
      end
      n_cmp++; if (rs_err !== 1'b0) begin n_bad++; $display("FAIL ret_err_early got %b want 0", rs_err); end
      run_instr(8'hC3, 3'd0, 4'h0, 4'h0, 8'h77);
      n_cmp++; if (pc_out !== 8'h04) begin n_bad++; $display("FAIL ret_under_pc got %h want 04", pc_out); end
      n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL ret_under_taken got %b want 0", taken); end
      n_cmp++; if (rs_err !== 1'b1) begin n_bad++; $display("FAIL ret_under_err got %b want 1", rs_err); end
   endtask

   task automatic test_wrap();
      run_instr(8'hC0, 3'd0, 4'h0, 4'h0, 8'hFF);
      run_instr(8'h00, 3'd0, 4'h0, 4'h0, 8'h33);
      n_cmp++; if (pc_out !== 8'h00) begin n_bad++; $display("FAIL wrap_pc got %h want 00", pc_out); end
      n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL wrap_taken got %b want 0", taken); end
   endtask

   task automatic test_illegal_phase();
      run_instr(8'hC0, 3'd0, 4'h0, 4'h0, 8'h20);
      op1 = 8'hC0; target = 8'h55;
      pulse(P_F | P_D);
      pulse(P_W | P_D);
      pulse(P_F | P_W);
      pulse(5'b00000);
      pulse(P_X);
      pulse(P_M);
      n_cmp++; if (pc_out !== 8'h20) begin n_bad++; $display("FAIL illegal_pc got %h want 20", pc_out); end
      n_cmp++; if (taken !== 1'b1) begin n_bad++; $display("FAIL illegal_taken got %b want 1", taken); end
      pulse(P_F);
      n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL fetch_clear_taken got %b want 0", taken); end
      pulse(P_W);
      n_cmp++; if (pc_out !== 8'h21) begin n_bad++; $display("FAIL w_no_latch_pc got %h want 21", pc_out); end
      m_pc = 8'h21; m_taken = 0;
   endtask

   task automatic test_reset_pending();
      run_instr(8'hC0, 3'd0, 4'h0, 4'h0, 8'h30);
      op1 = 8'hC2; target = 8'h90; op3 = '0;
      pulse(P_F);
      pulse(P_D);
      @(negedge clk); rst = 1'b0;
      #2;
      n_cmp++; if (pc_out !== 8'h00) begin n_bad++; $display("FAIL rst_mid_pc got %h want 00", pc_out); end
      n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL rst_mid_taken got %b want 0", taken); end
      @(negedge clk); rst = 1'b1;
      model_reset();
      pulse(P_X);
      pulse(P_M);
      pulse(P_W);
      n_cmp++; if (pc_out !== 8'h01) begin n_bad++; $display("FAIL rst_discard_pc got %h want 01", pc_out); end
      n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL rst_discard_taken got %b want 0", taken); end
      m_pc = 1;
      run_instr(8'hC3, 3'd0, 4'h0, 4'h0, 8'h90);
      n_cmp++; if (pc_out !== 8'h02) begin n_bad++; $display("FAIL rst_stack_empty_pc got %h want 02", pc_out); end
      n_cmp++; if (rs_err !== 1'b1) begin n_bad++; $display("FAIL rst_stack_empty_err got %b want 1", rs_err); end
   endtask

   task automatic test_random();
      logic [7:0] o1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 7))
            0:       o1 = 8'hC0;
            1, 2:    o1 = 8'hC1;
            3:       o1 = 8'hC2;
            4:       o1 = 8'hC3;
            default: o1 = 8'($urandom);
         endcase
         run_instr(o1, 3'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
         n_cmp++; if (pc_out !== 8'(m_pc)) begin n_bad++; $display("FAIL rnd%0d_pc op %h got %h want %h", i, o1, pc_out, 8'(m_pc)); end
         n_cmp++; if (taken !== m_taken) begin n_bad++; $display("FAIL rnd%0d_taken op %h got %b want %b", i, o1, taken, m_taken); end
         n_cmp++; if (rs_err !== m_err) begin n_bad++; $display("FAIL rnd%0d_err op %h got %b want %b", i, o1, rs_err, m_err); end
         if ($urandom_range(0, 7) == 0) begin
            pulse(P_F);
            m_taken = 0;
            n_cmp++; if (taken !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_fclear got %b want 0", i, taken); end
         end
      end
   endtask

   task automatic test_random_fresh();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      model_reset();
      test_random();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_sequential();
      test_jcc_flags_after_decode();
      test_call_ret();
      test_wrap();
      test_illegal_phase();
      test_reset_pending();
      test_random_fresh();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
